div8_seq: RTL

Iterative 8-bit unsigned restoring divider, the inverse datapath of the team's multiply/add chain. It accepts a dividend and divisor on a start pulse and resolves one quotient bit per clock. Each trial subtraction is performed by the existing 8-bit carry-select adder `csa8`, computing a + ~b with cin=1. The block sits beside the complex-multiplier datapath for normalisation and scaling and hands results back through a done pulse.

---
 rtl/div8_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/div8_seq.sv
// Iterative 8-bit unsigned restoring divider: one quotient bit per clock,
// trial subtraction through the csa8 carry-select adder (a + ~b + 1).

module csa8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_lo;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;
  logic [4:0] w_hi_sel;

  // Upper nibble is precomputed for both carries; the low-nibble carry picks one.
  always_comb begin
    w_lo     = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0000, i_cin};
    w_hi0    = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
    w_hi1    = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'd1;
    w_hi_sel = w_lo[4] ? w_hi1 : w_hi0;
    o_sum    = {w_hi_sel[3:0], w_lo[3:0]};
    o_cout   = w_hi_sel[4];
  end
endmodule

module div8_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_q;
  logic [7:0] r_r;
  logic [7:0] r_d;
  logic [2:0] r_count;

  logic [8:0] w_s;
  logic [7:0] w_diff;
  logic       w_cout;
  logic       w_ok;
  logic [7:0] w_r_next;
  logic [7:0] w_q_next;

  assign w_s = {r_r, r_q[7]};

  csa8 u_csa8 (
    .i_a    (w_s[7:0]),
    .i_b    (~r_d),
    .i_cin  (1'b1),
    .o_sum  (w_diff),
    .o_cout (w_cout)
  );

  // A set S[8] means S already exceeds any 8-bit divisor, so the subtract succeeds.
  always_comb begin
    w_ok     = w_s[8] | w_cout;
    w_r_next = w_ok ? w_diff : w_s[7:0];
    w_q_next = {r_q[6:0], w_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = (divisor == 8'd0) ? S_DONE : S_RUN;
      S_RUN:  if (r_count == 3'd7) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_count     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != 8'd0) begin
              r_q         <= dividend;
              r_r         <= '0;
              r_d         <= divisor;
              r_count     <= '0;
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_q     <= w_q_next;
          r_r     <= w_r_next;
          r_count <= r_count + 3'd1;
          if (r_count == 3'd7) begin
            quotient  <= w_q_next;
            remainder <= w_r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
endmodule
